// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the async SRAM access sequencer.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WSTROBE = 3'd2,
    S_RSTROBE = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  localparam int unsigned DEF_WR_PULSE = 2;
  localparam int unsigned DEF_RD_WAIT  = 2;

  // Down-counter width able to hold the larger pulse length minus one.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/strobe_timer.sv
// Loadable down-counter timing the strobe-low phase; done_c flags terminal count.
module strobe_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between load/store stage and async active-low SRAM.
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject addresses beyond the RAM depth.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned WR_PULSE   = DEF_WR_PULSE,
  parameter int unsigned RD_WAIT    = DEF_RD_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_cs_n,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = cnt_width(WR_PULSE, RD_WAIT);

  if (WR_PULSE < 1 || RD_WAIT < 1 || DEPTH_LOG2 > ADDR_W) begin : g_param_check
    $error("mem_access_ctrl: illegal parameter combination");
  end

  state_t           state;
  logic             we_q;
  logic             load_c;
  logic [CNT_W-1:0] load_val_c;
  logic             done_c;

  // Timer is armed while leaving SETUP, with the pulse length of the latched direction.
  assign load_c     = (state == S_SETUP);
  assign load_val_c = we_q ? CNT_W'(WR_PULSE - 1) : CNT_W'(RD_WAIT - 1);

  strobe_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_val (load_val_c),
    .done_c   (done_c)
  );

`ifdef MEM_BOUNDS_CHECK_EN
  logic oor_c;
  assign oor_c = (req_addr >> DEPTH_LOG2) != '0;
`else
  assign rsp_err = 1'b0;
`endif

  // Strobes and handshake are registered alongside the state so no decode glitches reach the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_cs_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            we_q      <= req_we;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
            rsp_err   <= oor_c;
            if (oor_c) begin
              state     <= S_RECOVER;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_SETUP;
            end
`else
            state <= S_SETUP;
`endif
          end
        end
        S_SETUP: begin
          mem_cs_n <= 1'b0;
          if (we_q) begin
            mem_we_n <= 1'b0;
            state    <= S_WSTROBE;
          end else begin
            mem_oe_n <= 1'b0;
            state    <= S_RSTROBE;
          end
        end
        S_WSTROBE: begin
          if (done_c) begin
            mem_cs_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RECOVER;
          end
        end
        S_RSTROBE: begin
          if (done_c) begin
            mem_cs_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            rsp_rdata <= mem_rdata;
            rsp_valid <= 1'b1;
            state     <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          mem_cs_n  <= 1'b1;
          mem_we_n  <= 1'b1;
          mem_oe_n  <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: default-timing instance plus a WR_PULSE=1/RD_WAIT=4 instance, each behind a RAM model.
module tb_mem_access_ctrl;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  int          sel;

  logic        va, vb;
  assign va = req_valid && (sel == 0);
  assign vb = req_valid && (sel == 1);

  logic        a_ready, a_rsp_valid, a_err, a_busy, a_cs, a_we, a_oe;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic        b_ready, b_rsp_valid, b_err, b_busy, b_cs, b_we, b_oe;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;

  mem_access_ctrl dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(a_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
    .rsp_err(a_err), .busy(a_busy), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_cs_n(a_cs), .mem_we_n(a_we), .mem_oe_n(a_oe), .mem_rdata(a_mrdata)
  );

  mem_access_ctrl #(.WR_PULSE(1), .RD_WAIT(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(b_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .rsp_err(b_err), .busy(b_busy), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_cs_n(b_cs), .mem_we_n(b_we), .mem_oe_n(b_oe), .mem_rdata(b_mrdata)
  );

  // Async 256-word RAMs; only 8 address lines reach the array.
  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  always @(posedge clk) if (!a_cs && !a_we) ram_a[a_maddr[7:0]] <= a_mwdata;
  always @(posedge clk) if (!b_cs && !b_we) ram_b[b_maddr[7:0]] <= b_mwdata;
  assign a_mrdata = (!a_cs && !a_oe) ? ram_a[a_maddr[7:0]] : 32'hDEAD_BEEF;
  assign b_mrdata = (!b_cs && !b_oe) ? ram_b[b_maddr[7:0]] : 32'hDEAD_BEEF;

  logic        cur_ready, cur_rsp_valid, cur_err, cur_busy;
  logic [31:0] cur_rdata;
  assign cur_ready     = (sel == 1) ? b_ready     : a_ready;
  assign cur_rsp_valid = (sel == 1) ? b_rsp_valid : a_rsp_valid;
  assign cur_err       = (sel == 1) ? b_err       : a_err;
  assign cur_busy      = (sel == 1) ? b_busy      : a_busy;
  assign cur_rdata     = (sel == 1) ? b_rdata     : a_rdata;

  // Reference model: word store per instance plus the last returned read word.
  logic [31:0] ref_a [int];
  logic [31:0] ref_b [int];
  logic [31:0] last_rd [2];

  int          n_cmp, n_fail, cyc;
  int          a_cs_cnt, b_cs_cnt;
  bit          a_prev_low, b_prev_low;
  logic [31:0] a_prev_addr, b_prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and run the always-on strobe checks.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("a_we_oe_exclusive", 32'(a_we | a_oe), 32'd1);
    chk("b_we_oe_exclusive", 32'(b_we | b_oe), 32'd1);
    if (!a_cs && a_prev_low) chk("a_addr_stable_cs", a_maddr, a_prev_addr);
    if (!b_cs && b_prev_low) chk("b_addr_stable_cs", b_maddr, b_prev_addr);
    a_prev_low = !a_cs; a_prev_addr = a_maddr;
    b_prev_low = !b_cs; b_prev_addr = b_maddr;
    if (!a_cs) a_cs_cnt++;
    if (!b_cs) b_cs_cnt++;
  endtask

  function automatic logic [31:0] ref_get(input logic [31:0] addr);
    if (sel == 1) return ref_b.exists(int'(addr[7:0])) ? ref_b[int'(addr[7:0])] : 32'hX;
    return ref_a.exists(int'(addr[7:0])) ? ref_a[int'(addr[7:0])] : 32'hX;
  endfunction

  function automatic bit ref_has(input logic [31:0] addr);
    return (sel == 1) ? ref_b.exists(int'(addr[7:0])) : ref_a.exists(int'(addr[7:0]));
  endfunction

  task automatic ref_put(input logic [31:0] addr, input logic [31:0] data);
    if (sel == 1) ref_b[int'(addr[7:0])] = data;
    else          ref_a[int'(addr[7:0])] = data;
  endtask

  // One complete access on the selected instance, checked against the model.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit exp_err);
    int          lat, pulse, cs_seen;
    logic [31:0] exp_rd;
    pulse = we ? ((sel == 1) ? 1 : 2) : ((sel == 1) ? 4 : 2);
    for (int i = 0; i < 20 && !cur_ready; i++) tick();
    chk("ready_before_req", 32'(cur_ready), 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    a_cs_cnt = 0; b_cs_cnt = 0;
    tick();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (lat = 1; lat <= 20; lat++) begin
      chk("busy_during_access", 32'(cur_busy), 32'd1);
      chk("ready_during_access", 32'(cur_ready), 32'd0);
      if (cur_rsp_valid) break;
      tick();
    end
    chk("latency", 32'(lat), exp_err ? 32'd1 : 32'(2 + pulse));
    chk("rsp_err", 32'(cur_err), 32'(exp_err));
    exp_rd = (!we && !exp_err) ? ref_get(addr) : last_rd[sel];
    chk("rsp_rdata", cur_rdata, exp_rd);
    last_rd[sel] = exp_rd;
    if (we && !exp_err) ref_put(addr, wdata);
    tick();
    chk("rsp_valid_one_cycle", 32'(cur_rsp_valid), 32'd0);
    chk("ready_after_access", 32'(cur_ready), 32'd1);
    cs_seen = (sel == 1) ? b_cs_cnt : a_cs_cnt;
    chk("cs_low_cycles", 32'(cs_seen), exp_err ? 32'd0 : 32'(pulse));
  endtask

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    int          k, nrsp, last_rsp;
    logic [31:0] addr;
    n_cmp = 0; n_fail = 0; cyc = 0; sel = 0;
    a_prev_low = 0; b_prev_low = 0; a_prev_addr = '0; b_prev_addr = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    tick(); tick();

    chk("rst_a_strobes", 32'({a_cs, a_we, a_oe}), 32'd7);
    chk("rst_b_strobes", 32'({b_cs, b_we, b_oe}), 32'd7);
    chk("rst_a_ready_busy", 32'({a_ready, a_busy}), 32'd2);
    chk("rst_a_rsp", 32'({a_rsp_valid, a_err}), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_a_maddr", a_maddr, 32'd0);
    chk("rst_a_mwdata", a_mwdata, 32'd0);
    rst = 1'b0;
    tick();

    // Directed write then read at 0x10.
    access(1'b1, 32'h10, 32'hA5A5_0001, 1'b0);
    access(1'b0, 32'h10, 32'h0, 1'b0);

    // Held req_valid: three writes accepted one at a time.
    for (int i = 0; i < 20 && !a_ready; i++) tick();
    req_we = 1'b1; req_addr = 32'd0; req_wdata = 32'd1; req_valid = 1'b1;
    k = 1; nrsp = 0; last_rsp = 0;
    for (int i = 0; i < 60 && nrsp < 3; i++) begin
      tick();
      chk("b2b_ready_vs_busy", 32'(a_ready), 32'(!a_busy));
      if (a_rsp_valid) begin
        if (nrsp > 0) chk("b2b_rsp_spacing", 32'(cyc - last_rsp), 32'd5);
        last_rsp = cyc;
        nrsp++;
      end
      if (k < 3 && a_ready) begin
        req_addr = 32'(k); req_wdata = 32'(k + 1); k++;
      end else if (k == 3 && !a_ready) begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_rsp_valid) nrsp++;
    end
    chk("b2b_rsp_count", 32'(nrsp), 32'd3);
    for (int i = 0; i < 3; i++) ref_put(32'(i), 32'(i + 1));
    for (int i = 0; i < 3; i++) access(1'b0, 32'(i), 32'h0, 1'b0);

    // Reset in the middle of a write strobe.
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFE_0040; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && a_we; i++) tick();
    chk("rst_mid_we_low", 32'(a_we), 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_mid_strobes", 32'({a_cs, a_we, a_oe}), 32'd7);
    chk("rst_mid_ready_busy", 32'({a_ready, a_busy}), 32'd2);
    chk("rst_mid_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_mid_rdata", a_rdata, 32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    rst = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_rsp_valid) nrsp++;
    end
    chk("rst_mid_no_rsp", 32'(nrsp), 32'd0);
    access(1'b0, 32'h10, 32'h0, 1'b0);

    // Address range edges.
    access(1'b1, 32'h00, 32'h1234_5678, 1'b0);
    access(1'b1, 32'hFF, 32'h0BAD_F00D, 1'b0);
    access(1'b0, 32'hFF, 32'h0, 1'b0);
    access(1'b0, 32'h100, 32'h0, BOUNDS);
    access(1'b0, 32'h00, 32'h0, 1'b0);

    // Random traffic on the default instance.
    for (int i = 0; i < 24; i++) begin
      addr = 32'($urandom_range(255));
      if (ref_has(addr) && $urandom_range(1) == 1) access(1'b0, addr, 32'h0, 1'b0);
      else                                          access(1'b1, addr, $urandom, 1'b0);
    end

    // Short-write / long-read instance.
    sel = 1;
    access(1'b1, 32'h22, 32'h5A5A_1234, 1'b0);
    access(1'b0, 32'h22, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      addr = 32'($urandom_range(255));
      if (ref_has(addr) && $urandom_range(1) == 1) access(1'b0, addr, 32'h0, 1'b0);
      else                                          access(1'b1, addr, $urandom, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
